uart_tx_processor: RTL and testbench
====================================

Name: uart_tx_processor

Overview:
UART transmitter that serialises one frame of 5–9 data bits onto the Tx line, with optional parity and 1 or 2 stop bits. It is the transmit-side counterpart of the receive processor. It takes the same line configuration (parity, parity_type, stop_bits, frame_length) from the UART register file. It runs on the 16x-baud clock and holds each bit on the line for 16 clock cycles.

Parameters:
OVERSAMPLE, 16, clock cycles per bit period.
MIN_LEN, 5, smallest data-bit count; smaller frame_length values clamp to this.
MAX_LEN, 9, largest data-bit count; larger frame_length values clamp to this.

Ports:
clk_16bd  input  1  16x-baud clock
rst  input  1  asynchronous, active-low reset
frame_valid  input  1  frame offered on frame
frame  input  9  data bits, LSB transmitted first; bits at or above the effective length are ignored
frame_ready  output  1  transmitter can accept a frame this cycle
parity  input  1  1 = parity bit enabled
parity_type  input  1  0 = even, 1 = odd
stop_bits  input  1  0 = one stop bit, 1 = two stop bits
frame_length  input  4  data-bit count, clamped to MIN_LEN..MAX_LEN
Tx  output  1  serial line, idle high
busy  output  1  high while a frame is on the line
tx_done  output  1  one-cycle pulse in the final cycle of the last stop bit

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, Tx=1, busy=0, tx_done=0, all counters 0, shift register 0. frame_ready=1 once state is IDLE.
- Handshake: a frame is accepted on a rising edge where frame_valid && frame_ready.
  - frame_ready is combinational from state: 1 in IDLE, and 1 in the last cycle of the last stop bit; 0 otherwise.
  - frame_valid without frame_ready is held off with no side effects. The source keeps frame stable until accepted.
- On acceptance, latch frame, the effective length, parity, parity_type and stop_bits. Config changes mid-frame have no effect until the next acceptance.
- Parity bit = XOR of the effective data bits, inverted when parity_type=1.
- States and transitions:
  - IDLE: Tx=1. On accept -> START.
  - START: Tx=0 for OVERSAMPLE cycles -> DATA.
  - DATA: Tx = shift[0], each bit held OVERSAMPLE cycles, shift right after each bit.
    - After the effective length of bits -> PARITY if parity enabled, else STOP.
  - PARITY: Tx = parity bit for OVERSAMPLE cycles -> STOP.
  - STOP: Tx=1 for OVERSAMPLE cycles, or 2*OVERSAMPLE if stop_bits=1.
    - In the last cycle tx_done=1.
    - If a frame is accepted in that cycle -> START with no idle gap, else -> IDLE.
- Latency: Tx falls on the first clock edge after acceptance (registered output). Total frame = (1 + len + parity + 1 + stop_bits) * OVERSAMPLE cycles.
- busy = 1 from the edge after acceptance until the state returns to IDLE. It stays 1 across back-to-back frames.
- Cycle counter: 4 bits at OVERSAMPLE=16, wraps 15->0 at each bit boundary. The bit counter is 4 bits, compared against the latched effective length.
- frame_length clamping: 0..4 -> 5, 10..15 -> 9.
- Reset mid-frame: Tx returns high immediately (asynchronous), the frame is discarded and no tx_done is issued.

Decomposition:
- Shared UART constants file/package (also used by the receive side):
  - state encodings IDLE/START/DATA/PARITY/STOP
  - OVERSAMPLE, MIN_LEN, MAX_LEN
  - parity_type encoding (EVEN=0, ODD=1)
- One sub-module, uart_bit_timer: OVERSAMPLE-cycle counter with clear input and bit_end pulse. It is reusable by the receiver.
- FSM, shift register and parity logic stay in uart_tx_processor.

Test Plan:
1. 8N1 (frame_length=8, parity=0, stop_bits=0), frame=0x055 -> Tx = 0,1,0,1,0,1,0,1,0,1, each level 16 cycles, 160 cycles total; tx_done pulses at cycle 160; frame_ready back to 1.
2. 7E2, frame=0x041 -> start, bits 1,0,0,0,0,0,1, parity 0, 32 cycles high; 176 cycles total.
3. 9O1, frame=0x1FF (nine ones, odd parity) -> parity bit 0; 9E1 on the same frame -> parity bit 1; 192 cycles each.
4. Back-to-back: frame_valid held high with 0x0A3 then 0x15C at 8N1 -> second start bit begins the cycle after the first tx_done; busy never drops; no idle gap.
5. Config change mid-frame: parity toggled during DATA -> current frame unchanged, next frame uses the new setting. frame_length=3 -> 5 data bits sent (clamp).
6. rst pulsed low during DATA of frame 0x0F0 -> Tx=1 and busy=0 immediately; no tx_done; a frame accepted after release transmits correctly.

Source files
------------

// File: rtl/uart_tx_processor_pkg.sv
// Shared UART line definitions: state encodings, framing limits and config helpers.
// Used by both the transmit and receive processors.
package uart_tx_processor_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MIN_LEN    = 5;
    localparam int unsigned MAX_LEN    = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } parity_type_e;

    // Line configuration captured once per frame.
    typedef struct packed {
        logic [3:0] len;
        logic       par_en;
        logic       par_bit;
        logic       stop2;
    } frame_cfg_t;

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        if (len < 4'(MIN_LEN)) return 4'(MIN_LEN);
        if (len > 4'(MAX_LEN)) return 4'(MAX_LEN);
        return len;
    endfunction

    // XOR of the first len data bits, inverted for odd parity.
    function automatic logic calc_parity(input logic [8:0] data, input logic [3:0] len,
                                         input parity_type_e ptype);
        logic p;
        p = (ptype == PAR_ODD);
        for (int i = 0; i < 9; i++) begin
            if (4'(i) < len) p = p ^ data[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: free-runs 0..OVERSAMPLE-1 while not cleared and flags the
// final cycle of every bit period. Shared by the transmit and receive paths.
module uart_bit_timer
    import uart_tx_processor_pkg::*;
#(
    parameter int unsigned OVERSAMPLE_CYC = OVERSAMPLE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic bit_end_o
);

    localparam int unsigned CW = (OVERSAMPLE_CYC > 1) ? $clog2(OVERSAMPLE_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: next-state gets a default before any condition so no latch is inferred.
        cnt_d = cnt_q + CW'(1);
        if (clear_i || (cnt_q == LAST)) cnt_d = '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign bit_end_o = !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_processor.sv
// UART transmitter: serialises a 5..9 bit frame with optional parity and 1/2 stop
// bits, holding each bit for OVERSAMPLE cycles of the 16x-baud clock.
module uart_tx_processor
    import uart_tx_processor_pkg::*;
(
    input  logic       clk_16bd,
    input  logic       rst,
    input  logic       frame_valid,
    input  logic [8:0] frame,
    output logic       frame_ready,
    input  logic       parity,
    input  logic       parity_type,
    input  logic       stop_bits,
    input  logic [3:0] frame_length,
    output logic       Tx,
    output logic       busy,
    output logic       tx_done
);

    uart_state_e state_q;
    frame_cfg_t  cfg_q;
    frame_cfg_t  load_cfg;
    logic [8:0]  shift_q;
    logic [3:0]  bit_cnt_q;
    logic        tx_q;
    logic        busy_q;

    logic bit_end;
    logic last_stop;
    logic frame_end;
    logic accept;

    uart_bit_timer #(.OVERSAMPLE_CYC(OVERSAMPLE)) u_bit_timer (
        .clk       (clk_16bd),
        .rst_n     (rst),
        .clear_i   (state_q == ST_IDLE),
        .bit_end_o (bit_end)
    );

    assign load_cfg.len     = clamp_len(frame_length);
    assign load_cfg.par_en  = parity;
    assign load_cfg.par_bit = calc_parity(frame, clamp_len(frame_length), parity_type_e'(parity_type));
    assign load_cfg.stop2   = stop_bits;

    assign last_stop   = (bit_cnt_q == {3'b000, cfg_q.stop2});
    assign frame_end   = (state_q == ST_STOP) && bit_end && last_stop;
    // Ready in the closing stop cycle lets a waiting frame start with no idle gap.
    assign frame_ready = (state_q == ST_IDLE) || frame_end;
    assign accept      = frame_valid && frame_ready;

    always_ff @(posedge clk_16bd or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cfg_q     <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cfg_q     <= load_cfg;
                        shift_q   <= frame;
                        bit_cnt_q <= '0;
                        state_q   <= ST_START;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_q <= ST_DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt_q == cfg_q.len - 4'd1) begin
                            bit_cnt_q <= '0;
                            state_q   <= cfg_q.par_en ? ST_PARITY : ST_STOP;
                            tx_q      <= cfg_q.par_en ? cfg_q.par_bit : 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            tx_q      <= shift_q[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state_q   <= ST_STOP;
                        bit_cnt_q <= '0;
                        tx_q      <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (!last_stop) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (accept) begin
                            cfg_q     <= load_cfg;
                            shift_q   <= frame;
                            bit_cnt_q <= '0;
                            state_q   <= ST_START;
                            tx_q      <= 1'b0;
                        end else begin
                            bit_cnt_q <= '0;
                            state_q   <= ST_IDLE;
                            tx_q      <= 1'b1;
                            busy_q    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = frame_end;

endmodule

// File: tb/tb_uart_tx_processor.sv
// Scoreboard bench for uart_tx_processor: a line-level model predicts each frame's
// waveform at acceptance and a monitor checks the Tx line, busy, frame_ready and tx_done.
module tb_uart_tx_processor;

    localparam int OS = 16;

    logic       clk_16bd     = 1'b0;
    logic       rst          = 1'b1;
    logic       frame_valid  = 1'b0;
    logic [8:0] frame        = '0;
    logic       parity       = 1'b0;
    logic       parity_type  = 1'b0;
    logic       stop_bits    = 1'b0;
    logic [3:0] frame_length = 4'd8;
    logic       frame_ready;
    logic       Tx;
    logic       busy;
    logic       tx_done;

    typedef struct {
        logic [15:0] lvl;
        int          nbits;
        bit          b2b;
        logic [8:0]  data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks  = 0;
    int   n_bad     = 0;
    bit   hold_prev = 1'b0;

    uart_tx_processor dut (
        .clk_16bd     (clk_16bd),
        .rst          (rst),
        .frame_valid  (frame_valid),
        .frame        (frame),
        .frame_ready  (frame_ready),
        .parity       (parity),
        .parity_type  (parity_type),
        .stop_bits    (stop_bits),
        .frame_length (frame_length),
        .Tx           (Tx),
        .busy         (busy),
        .tx_done      (tx_done)
    );

    always #5 clk_16bd = ~clk_16bd;

    function automatic int b2i(input logic v);
        if (v === 1'b1) return 1;
        if (v === 1'b0) return 0;
        return -1;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_bad++;
        $display("FAIL %s: got no event, expected one within bound", name);
    endtask

    // Line-level expectation: start 0, data LSB first, optional parity, stop 1s.
    function automatic exp_t model(input logic [8:0] f, input int flen, input bit par,
                                   input bit pt, input bit sb, input bit b2b);
        exp_t e;
        int   len;
        int   ones;
        int   n;
        len   = (flen < 5) ? 5 : ((flen > 9) ? 9 : flen);
        ones  = 0;
        n     = 0;
        e.lvl = '1;
        e.lvl[n] = 1'b0;
        n++;
        for (int i = 0; i < len; i++) begin
            e.lvl[n] = f[i];
            ones += int'(f[i]);
            n++;
        end
        if (par) begin
            e.lvl[n] = ((ones % 2) == 1) ^ pt;
            n++;
        end
        n += sb ? 2 : 1;
        e.nbits = n;
        e.b2b   = b2b;
        e.data  = f;
        return e;
    endfunction

    task automatic send(input logic [8:0] f, input int flen, input bit par, input bit pt,
                        input bit sb, input bit hold);
        int wait_cyc;
        @(negedge clk_16bd);
        frame        = f;
        frame_length = 4'(flen);
        parity       = par;
        parity_type  = pt;
        stop_bits    = sb;
        frame_valid  = 1'b1;
        wait_cyc     = 0;
        while (frame_ready !== 1'b1 && wait_cyc < 400) begin
            @(negedge clk_16bd);
            wait_cyc++;
        end
        if (frame_ready !== 1'b1) begin
            fail_event($sformatf("accept_timeout_frame_%03h", f));
            frame_valid = 1'b0;
            hold_prev   = 1'b0;
            return;
        end
        sb_q.push_back(model(f, flen, par, pt, sb, hold_prev));
        @(posedge clk_16bd);
        #1;
        if (!hold) frame_valid = 1'b0;
        hold_prev = hold;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk_16bd);
            n++;
        end while (busy !== 1'b0 && n < 400);
        check({tag, "_busy_low"}, b2i(busy), 0);
        check({tag, "_ready_high"}, b2i(frame_ready), 1);
    endtask

    // Monitor: a frame begins at the first sampled low on Tx.
    initial begin : monitor
        exp_t e;
        int   idle;
        int   fidx;
        int   total;
        int   match[16];
        int   busy_cnt;
        int   rdy_cnt;
        int   done_cnt;
        int   done_pos;
        bit   aborted;
        idle = 1000;
        fidx = 0;
        forever begin
            @(negedge clk_16bd);
            if (!rst || Tx !== 1'b0) begin
                idle++;
                continue;
            end
            if (sb_q.size() == 0) begin
                fail_event("unexpected_start_no_frame_queued");
                for (int k = 0; k < 300 && Tx === 1'b0; k++) @(negedge clk_16bd);
                idle = 0;
                continue;
            end
            e        = sb_q.pop_front();
            total    = e.nbits * OS;
            busy_cnt = 0;
            rdy_cnt  = 0;
            done_cnt = 0;
            done_pos = -1;
            aborted  = 1'b0;
            for (int i = 0; i < 16; i++) match[i] = 0;
            for (int c = 0; c < total; c++) begin
                if (c > 0) @(negedge clk_16bd);
                if (!rst) begin
                    aborted = 1'b1;
                    break;
                end
                if (Tx === e.lvl[c / OS]) match[c / OS]++;
                if (busy === 1'b1) busy_cnt++;
                if (frame_ready === 1'b1) rdy_cnt++;
                if (tx_done === 1'b1) begin
                    done_cnt++;
                    done_pos = c;
                end
            end
            if (!aborted) begin
                if (e.b2b) check($sformatf("f%0d_%03h_b2b_idle_gap", fidx, e.data), idle, 0);
                for (int i = 0; i < e.nbits; i++)
                    check($sformatf("f%0d_%03h_bit%0d_cycles_at_level_%0d", fidx, e.data, i,
                                    int'(e.lvl[i])), match[i], OS);
                check($sformatf("f%0d_%03h_tx_done_pulses", fidx, e.data), done_cnt, 1);
                check($sformatf("f%0d_%03h_tx_done_cycle", fidx, e.data), done_pos, total - 1);
                check($sformatf("f%0d_%03h_busy_cycles", fidx, e.data), busy_cnt, total);
                check($sformatf("f%0d_%03h_ready_cycles", fidx, e.data), rdy_cnt, 1);
            end
            fidx++;
            idle = 0;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int done_seen;
        #2 rst = 1'b0;
        #13;
        check("reset_tx", b2i(Tx), 1);
        check("reset_busy", b2i(busy), 0);
        check("reset_tx_done", b2i(tx_done), 0);
        check("reset_frame_ready", b2i(frame_ready), 1);
        repeat (2) @(negedge clk_16bd);
        rst = 1'b1;

        // 8N1, 7E2, 9O1 and 9E1 on all-ones data.
        send(9'h055, 8, 1'b0, 1'b0, 1'b0, 1'b0);  wait_idle("8n1");
        send(9'h041, 7, 1'b1, 1'b0, 1'b1, 1'b0);  wait_idle("7e2");
        send(9'h1FF, 9, 1'b1, 1'b1, 1'b0, 1'b0);  wait_idle("9o1");
        send(9'h1FF, 9, 1'b1, 1'b0, 1'b0, 1'b0);  wait_idle("9e1");

        // Back-to-back with frame_valid held high.
        send(9'h0A3, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        send(9'h15C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle("b2b");

        // Parity toggled mid-frame affects only the next frame; short length clamps to 5.
        send(9'h0C5, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (40) @(negedge clk_16bd);
        parity      = 1'b1;
        parity_type = 1'b1;
        stop_bits   = 1'b1;
        wait_idle("cfg_change_a");
        send(9'h0C5, 8, 1'b1, 1'b1, 1'b0, 1'b0);  wait_idle("cfg_change_b");
        send(9'h1F6, 3, 1'b1, 1'b0, 1'b0, 1'b0);  wait_idle("len3_clamp");
        send(9'h1A5, 15, 1'b0, 1'b0, 1'b1, 1'b0); wait_idle("len15_clamp");

        // Asynchronous reset during the data bits.
        send(9'h0F0, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (48) @(posedge clk_16bd);
        #3 rst = 1'b0;
        #1;
        check("midframe_reset_tx", b2i(Tx), 1);
        check("midframe_reset_busy", b2i(busy), 0);
        check("midframe_reset_ready", b2i(frame_ready), 1);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk_16bd);
            if (tx_done === 1'b1) done_seen++;
        end
        rst = 1'b1;
        repeat (240) begin
            @(negedge clk_16bd);
            if (tx_done === 1'b1) done_seen++;
        end
        check("midframe_reset_no_tx_done", done_seen, 0);
        send(9'h0F0, 8, 1'b0, 1'b0, 1'b0, 1'b0);  wait_idle("after_reset");

        // Randomised frames and configurations, some back-to-back.
        for (int i = 0; i < 24; i++) begin
            logic [8:0] f;
            int         flen;
            bit         par, pt, sb, hold;
            f    = 9'($urandom_range(0, 511));
            flen = $urandom_range(0, 15);
            par  = 1'($urandom_range(0, 1));
            pt   = 1'($urandom_range(0, 1));
            sb   = 1'($urandom_range(0, 1));
            hold = (i != 23) && ($urandom_range(0, 2) == 0);
            send(f, flen, par, pt, sb, hold);
            if (!hold && $urandom_range(0, 1) == 1) wait_idle("rand");
        end
        wait_idle("final");
        repeat (2) @(negedge clk_16bd);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
